// File: rtl/width_conv_fifo.sv
// width_conv_fifo: single-clock FIFO that stores wide write words and
// returns them as RATIO narrower slices, in MSB-first or LSB-first lane order.
// The level and flag outputs are registered and show the result of the
// operations accepted on the previous clock edge.
// Optional feature: define WCFIFO_OUTPUT_REG_EN to add one more register
// stage on rd_data, so read data arrives 2 cycles after an accepted read.
module width_conv_fifo #(
    parameter int    WR_DATA_WIDTH    = 256,
    parameter int    RATIO            = 8,
    parameter int    WR_DEPTH_WIDTH   = 8,
    parameter int    ALMOST_FULL_NUM  = 124,
    parameter int    ALMOST_EMPTY_NUM = 4,
    parameter string LANE_ORDER       = "MSB_FIRST"
) (
    input  logic                                        clk,
    input  logic                                        tb_rst,
    input  logic                                        flush,
    input  logic                                        wr_en,
    input  logic [WR_DATA_WIDTH-1:0]                    wr_data,
    output logic                                        wr_full,
    output logic [WR_DEPTH_WIDTH:0]                     wr_water_level,
    output logic                                        almost_full,
    input  logic                                        rd_en,
    output logic [WR_DATA_WIDTH/RATIO-1:0]              rd_data,
    output logic                                        rd_empty,
    output logic [WR_DEPTH_WIDTH+$clog2(RATIO):0]       rd_water_level,
    output logic                                        almost_empty
);

    localparam int RD_W   = WR_DATA_WIDTH / RATIO;
    localparam int LOG2R  = $clog2(RATIO);
    localparam int LANE_W = (LOG2R > 0) ? LOG2R : 1;
    localparam int WL_W   = WR_DEPTH_WIDTH + 1;
    localparam int RL_W   = WR_DEPTH_WIDTH + LOG2R + 1;
    localparam int DEPTH  = 2 ** WR_DEPTH_WIDTH;
    localparam bit LSB_FIRST = (LANE_ORDER == "LSB_FIRST");
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(RATIO - 1);
    localparam logic [WL_W-1:0]   FULL_LEVEL = WL_W'(DEPTH);
    localparam logic [WL_W-1:0]   AF_LEVEL   = WL_W'(ALMOST_FULL_NUM);
    localparam logic [RL_W-1:0]   AE_LEVEL   = RL_W'(ALMOST_EMPTY_NUM);

    // Pick lane 'lane' of a stored word according to the configured lane order.
    function automatic logic [RD_W-1:0] lane_slice(
        input logic [WR_DATA_WIDTH-1:0] word,
        input logic [LANE_W-1:0]        lane
    );
        logic [LANE_W-1:0] pos;
        logic [RD_W-1:0]   s;
        pos = LSB_FIRST ? lane : (LAST_LANE - lane);
        s   = {RD_W{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) == pos) begin
                s = word[i*RD_W +: RD_W];
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    logic [WR_DATA_WIDTH-1:0] mem_r [DEPTH];

    // Pointers carry one extra MSB so a full FIFO differs from an empty one.
    logic [WL_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LANE_W-1:0] lane_r;
    logic [WL_W-1:0]   wr_level_r;
    logic [RL_W-1:0]   rd_level_r;
    logic              wr_full_r, rd_empty_r, almost_full_r, almost_empty_r;
    logic [RD_W-1:0]   rd_data_r;

    logic              wr_acc_s, rd_acc_s, last_lane_s;
    logic [WL_W-1:0]   wr_ptr_nxt_s, rd_ptr_nxt_s, wr_level_nxt_s;
    logic [LANE_W-1:0] lane_nxt_s;
    logic [RL_W-1:0]   rd_level_nxt_s;
    logic [WR_DATA_WIDTH-1:0] rd_word_s;

    assign rd_word_s = mem_r[rd_ptr_r[WR_DEPTH_WIDTH-1:0]];

    // Accept decisions use the registered flags, then compute next pointers and levels.
    always_comb begin
        wr_acc_s    = wr_en & ~wr_full_r & ~flush;
        rd_acc_s    = rd_en & ~rd_empty_r & ~flush;
        last_lane_s = (lane_r == LAST_LANE);

        if (flush) begin
            wr_ptr_nxt_s = {WL_W{1'b0}};
            rd_ptr_nxt_s = {WL_W{1'b0}};
            lane_nxt_s   = {LANE_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_nxt_s = wr_ptr_r + WL_W'(1'b1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_acc_s && last_lane_s) begin
                lane_nxt_s   = {LANE_W{1'b0}};
                rd_ptr_nxt_s = rd_ptr_r + WL_W'(1'b1);
            end else if (rd_acc_s) begin
                lane_nxt_s   = lane_r + LANE_W'(1'b1);
                rd_ptr_nxt_s = rd_ptr_r;
            end else begin
                lane_nxt_s   = lane_r;
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end

        // Occupied words, a partially read word included.
        wr_level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
        rd_level_nxt_s = (RL_W'(wr_level_nxt_s) << LOG2R) - RL_W'(lane_nxt_s);
    end

    // Pointer, lane, level and flag registers; flush clears them synchronously.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr_r       <= {WL_W{1'b0}};
            rd_ptr_r       <= {WL_W{1'b0}};
            lane_r         <= {LANE_W{1'b0}};
            wr_level_r     <= {WL_W{1'b0}};
            rd_level_r     <= {RL_W{1'b0}};
            wr_full_r      <= 1'b0;
            rd_empty_r     <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            lane_r         <= lane_nxt_s;
            wr_level_r     <= wr_level_nxt_s;
            rd_level_r     <= rd_level_nxt_s;
            wr_full_r      <= (wr_level_nxt_s == FULL_LEVEL);
            rd_empty_r     <= (wr_level_nxt_s == {WL_W{1'b0}});
            almost_full_r  <= (wr_level_nxt_s >= AF_LEVEL);
            almost_empty_r <= (rd_level_nxt_s <= AE_LEVEL);
        end
    end

    // Storage array, written on accepted writes only; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r[WR_DEPTH_WIDTH-1:0]] <= wr_data;
        end
    end

    // Read slice register: loads on an accepted read, otherwise holds (also across flush).
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_data_r <= {RD_W{1'b0}};
        end else if (rd_acc_s) begin
            rd_data_r <= lane_slice(rd_word_s, lane_r);
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

`ifdef WCFIFO_OUTPUT_REG_EN
    logic [RD_W-1:0] rd_data_q_r;

    // Extra output stage for timing; follows rd_data_r one cycle later.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_data_q_r <= {RD_W{1'b0}};
        end else begin
            rd_data_q_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_q_r;
`else
    assign rd_data = rd_data_r;
`endif

    assign wr_full        = wr_full_r;
    assign wr_water_level = wr_level_r;
    assign almost_full    = almost_full_r;
    assign rd_empty       = rd_empty_r;
    assign rd_water_level = rd_level_r;
    assign almost_empty   = almost_empty_r;

endmodule

// File: tb/tb_width_conv_fifo.sv
// Testbench for width_conv_fifo: two instances (MSB_FIRST and LSB_FIRST)
// share one stimulus stream. A queue-based reference model predicts the
// read slices and levels; a negedge monitor compares the DUT outputs.
module tb_width_conv_fifo;

`ifdef WCFIFO_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         tb_rst = 1'b1;
    logic         flush = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [255:0] wr_data = '0;

    logic        m_full, m_af, m_empty, m_ae;
    logic [8:0]  m_wl;
    logic [11:0] m_rl;
    logic [31:0] m_data;
    logic        l_full, l_af, l_empty, l_ae;
    logic [8:0]  l_wl;
    logic [11:0] l_rl;
    logic [31:0] l_data;

    width_conv_fifo #(.LANE_ORDER("MSB_FIRST")) dut_msb (
        .clk(clk), .tb_rst(tb_rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(m_full), .wr_water_level(m_wl), .almost_full(m_af),
        .rd_en(rd_en), .rd_data(m_data),
        .rd_empty(m_empty), .rd_water_level(m_rl), .almost_empty(m_ae)
    );

    width_conv_fifo #(.LANE_ORDER("LSB_FIRST")) dut_lsb (
        .clk(clk), .tb_rst(tb_rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(l_full), .wr_water_level(l_wl), .almost_full(l_af),
        .rd_en(rd_en), .rd_data(l_data),
        .rd_empty(l_empty), .rd_water_level(l_rl), .almost_empty(l_ae)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit [31:0] msb;
        bit [31:0] lsb;
        int        due;
    } exp_t;

    exp_t         pend[$];
    logic [255:0] mq[$];
    int           lane = 0;
    int           cyc = 0;
    bit [31:0]    last_msb = '0;
    bit [31:0]    last_lsb = '0;
    bit           m_wa, m_ra;
    logic [255:0] m_w;
    exp_t         m_e;

    always @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            mq.delete();
            pend.delete();
            lane     = 0;
            last_msb = '0;
            last_lsb = '0;
        end else begin
            cyc++;
            m_wa = wr_en && !flush && (mq.size() < 256);
            m_ra = rd_en && !flush && (mq.size() > 0);
            if (flush) begin
                mq.delete();
                lane = 0;
            end else begin
                if (m_ra) begin
                    m_w     = mq[0];
                    m_e.msb = m_w[255 - lane*32 -: 32];
                    m_e.lsb = m_w[lane*32 +: 32];
                    m_e.due = cyc + LAT - 1;
                    pend.push_back(m_e);
                    lane++;
                    if (lane == 8) begin
                        lane = 0;
                        void'(mq.pop_front());
                    end
                end
                if (m_wa) mq.push_back(wr_data);
            end
        end
    end

    // ---------------- monitor ----------------
    int e_wl, e_rl;
    exp_t mon_e;

    always @(negedge clk) begin
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            mon_e    = pend.pop_front();
            last_msb = mon_e.msb;
            last_lsb = mon_e.lsb;
        end
        e_wl = mq.size();
        e_rl = e_wl * 8 - lane;
        chk("rd_data_msb", 64'(m_data), 64'(last_msb));
        chk("rd_data_lsb", 64'(l_data), 64'(last_lsb));
        chk("wr_level",    64'(m_wl), 64'(e_wl));
        chk("rd_level",    64'(m_rl), 64'(e_rl));
        chk("wr_full",     64'(m_full), 64'(e_wl == 256));
        chk("rd_empty",    64'(m_empty), 64'(e_wl == 0));
        chk("almost_full", 64'(m_af), 64'(e_wl >= 124));
        chk("almost_empty",64'(m_ae), 64'(e_rl <= 4));
        chk("lsb_status",  64'({l_full, l_empty, l_af, l_ae, l_wl, l_rl}),
                           64'({e_wl == 256, e_wl == 0, e_wl >= 124, e_rl <= 4, 9'(e_wl), 12'(e_rl)}));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit we, input bit re, input bit fl, input logic [255:0] d);
        @(negedge clk);
        wr_en   = we;
        rd_en   = re;
        flush   = fl;
        wr_data = d;
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    logic [255:0] seq_word;
    int wr_pct;

    initial begin
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;

        // Fill with 255-index in every slice, one extra write is dropped.
        for (int i = 0; i < 257; i++) step(1'b1, 1'b0, 1'b0, {8{32'(255 - i)}});
        // Drain all 2048 slices.
        for (int i = 0; i < 2048; i++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);   // read on empty is ignored
        step(1'b0, 1'b0, 1'b0, '0);

        // Lane-order word: slice k holds value k.
        for (int k = 0; k < 8; k++) seq_word[k*32 +: 32] = 32'(k);
        step(1'b1, 1'b0, 1'b0, seq_word);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, '0);

        // At full: 7 reads, then last-lane read with a write (write dropped).
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0, rand_word());
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, rand_word());
        // Drain to level 10, then last-lane read together with a write.
        for (int i = 0; i < 245 * 8; i++) step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, rand_word());
        step(1'b0, 1'b0, 1'b0, '0);

        // Flush mid-stream with wr_en=rd_en=1, then a fresh write/read pair.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, rand_word());
        step(1'b1, 1'b1, 1'b1, rand_word());
        step(1'b1, 1'b0, 1'b0, rand_word());
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset mid-stream with wr_en=rd_en=1.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, rand_word());
        #2 tb_rst = 1'b1;
        #1;
        chk("rst_wr_level", 64'(m_wl), 64'd0);
        chk("rst_rd_level", 64'(m_rl), 64'd0);
        chk("rst_empty",    64'({m_empty, m_ae, m_full, m_af}), 64'b1100);
        chk("rst_rd_data",  64'(m_data), 64'd0);
        step(1'b1, 1'b1, 1'b0, rand_word());
        tb_rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, rand_word());
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Random traffic with varying write pressure and occasional flush.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 4)
                0: wr_pct = 5;
                1: wr_pct = 15;
                2: wr_pct = 30;
                default: wr_pct = 80;
            endcase
            for (int i = 0; i < 500; i++)
                step($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < 70,
                     $urandom_range(0, 199) == 0, rand_word());
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, '0);
        chk("pending_drained", 64'(pend.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/width_conv_fifo.md
WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

Interface
REQ-001 The block SHALL have parameter WR_DATA_WIDTH, default 256, meaning the write word width in bits.
REQ-002 The block SHALL have parameter RATIO, default 8, meaning the write/read width ratio; it is a power of 2 in {1,2,4,8,16} and divides WR_DATA_WIDTH; RD_DATA_WIDTH = WR_DATA_WIDTH/RATIO.
REQ-003 The block SHALL have parameter WR_DEPTH_WIDTH, default 8, meaning the storage depth of 2**WR_DEPTH_WIDTH write words.
REQ-004 The block SHALL have parameter ALMOST_FULL_NUM, default 124, meaning the wr_water_level threshold for almost_full.
REQ-005 The block SHALL have parameter ALMOST_EMPTY_NUM, default 4, meaning the rd_water_level threshold for almost_empty.
REQ-006 The block SHALL have parameter LANE_ORDER, default "MSB_FIRST" (alternative "LSB_FIRST"), meaning which slice of a write word is read first.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock for both sides.
REQ-008 The block SHALL have port tb_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-010 The block SHALL have port wr_en, input, 1 bit, and port wr_data, input, WR_DATA_WIDTH bits: the write request and the write word.
REQ-011 The block SHALL have port wr_full, output, 1 bit; port wr_water_level, output, WR_DEPTH_WIDTH+1 bits; and port almost_full, output, 1 bit.
REQ-012 The block SHALL have port rd_en, input, 1 bit, and port rd_data, output, RD_DATA_WIDTH bits: the read request and the read slice.
REQ-013 The block SHALL have port rd_empty, output, 1 bit; port rd_water_level, output, WR_DEPTH_WIDTH+log2(RATIO)+1 bits; and port almost_empty, output, 1 bit.

Function
REQ-014 A write SHALL be accepted when wr_en=1, wr_full=0 and flush=0; wr_data is then stored at the write pointer and the pointer advances by 1, modulo 2**WR_DEPTH_WIDTH.
REQ-015 A read SHALL be accepted when rd_en=1, rd_empty=0 and flush=0; the lane index advances by 1, and on lane RATIO-1 it wraps to 0 and the read word pointer advances, freeing that word.
REQ-016 With LANE_ORDER="MSB_FIRST", lane k SHALL return wr_data[WR_DATA_WIDTH-1-k*RD_DATA_WIDTH -: RD_DATA_WIDTH]; with "LSB_FIRST", lane k SHALL return wr_data[k*RD_DATA_WIDTH +: RD_DATA_WIDTH].
REQ-017 rd_data SHALL be valid on the cycle after an accepted read and SHALL hold its value until the next accepted read.
REQ-018 wr_water_level SHALL equal the number of occupied write words, including a partially read word.
REQ-019 rd_water_level SHALL equal wr_water_level*RATIO minus the lane index.
REQ-020 wr_full SHALL be (wr_water_level == 2**WR_DEPTH_WIDTH), and rd_empty SHALL be (wr_water_level == 0).
REQ-021 almost_full SHALL be (wr_water_level >= ALMOST_FULL_NUM), and almost_empty SHALL be (rd_water_level <= ALMOST_EMPTY_NUM).
REQ-022 All status outputs SHALL be registered and SHALL reflect the accepted operations one cycle later.
REQ-023 Full and empty SHALL be evaluated at the start of the cycle: a write while full is dropped even if the same cycle's read frees a word, and a read while empty is ignored even if a write is accepted in the same cycle.
REQ-024 A simultaneous accepted write and last-lane read SHALL leave wr_water_level unchanged.
REQ-025 flush=1 SHALL clear the pointers, the lane index and the levels on the next edge, take priority over wr_en/rd_en, and leave rd_data unchanged.
REQ-026 Pointer wrap-around SHALL use an extra MSB so that the full and empty states are distinguished.

Reset
REQ-027 tb_rst=1 SHALL immediately set the pointers, the lane index, both water levels, wr_full, almost_full and rd_data to 0, and set rd_empty and almost_empty to 1.
REQ-028 Reset mid-operation SHALL discard all contents; the first accepted read after release SHALL return lane 0 of the first word written after release.
REQ-029 Storage RAM contents SHALL NOT be reset.

Configuration
REQ-030 When macro WCFIFO_OUTPUT_REG_EN is defined, the block SHALL add an output register stage, making rd_data valid 2 cycles after an accepted read (reset value 0); without the macro the latency SHALL be 1 cycle and the status timing SHALL be unchanged.

Verification
REQ-031 Defaults; write 256 words, the value being 255-index in every 32-bit slice -> wr_full=1 after the 256th write, a 257th write is dropped, wr_water_level=256.
REQ-032 Continue by reading 2048 slices -> MSB_FIRST data order, rd_empty=1 after the last slice, rd_water_level counts 2048 down to 0, almost_empty asserts at 4.
REQ-033 LANE_ORDER="LSB_FIRST"; write 0x...00000007_00000006_..._00000000 -> reads return 0,1,...,7.
REQ-034 At full, do 7 reads then the 8th read together with a write -> the write is dropped and the level is 255; repeat at level 10 -> the level stays 10.
REQ-035 Assert flush or tb_rst mid-stream with wr_en=rd_en=1 -> levels 0, rd_empty=1, and the next write/read pair returns the new data.
REQ-036 With WCFIFO_OUTPUT_REG_EN defined, run REQ-032 -> identical data stream delayed by one extra cycle.
